// File: rtl/fb_rect_writer_if.sv
// Request and frame-buffer write bundle for fb_rect_writer.
// master = requester side (game logic / bench), slave = the rectangle engine.
interface fb_rect_writer_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    // Handshake: a request transfers on a rising iVGA_CLK edge where
    // req_valid && req_ready; req_* must be stable while req_valid is high.
    // The write side has no back-pressure: each wr_en cycle is one pixel.
    logic              req_valid;
    logic              req_ready;
    logic [9:0]        req_x;
    logic [8:0]        req_y;
    logic [9:0]        req_w;
    logic [8:0]        req_h;
    logic [DATA_W-1:0] req_color;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output req_valid, req_x, req_y, req_w, req_h, req_color,
        input  req_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_x, req_y, req_w, req_h, req_color,
        output req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fb_rect_writer.sv
// Clipped filled-rectangle writer for the background frame buffer (port B).
// Define FB_WRITE_VBLANK_ONLY_EN to restrict pixel writes to vblank=1 cycles.
module fb_rect_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    fb_rect_writer_if.slave   bus,
    input  logic              vblank,
    output logic              busy,
    output logic              done,
    output logic              clip_flag,
    output logic [1:0]        state_dbg
);
    typedef enum logic [1:0] {IDLE, CLIP, WRITE, DONE} state_t;

    localparam logic [10:0] H_RES_L = 11'(H_RES);
    localparam logic [9:0]  V_RES_L = 10'(V_RES);

    state_t            state, stateNext;
    logic [9:0]        xQ, wQ, cx;
    logic [8:0]        yQ, hQ, cy;
    logic [10:0]       xEnd;
    logic [9:0]        yEnd;
    logic [ADDR_W-1:0] rowBase;
    logic [DATA_W-1:0] colorQ;

    logic        accept, empty, permit, lastCol, lastRow;
    logic [10:0] xSum;
    logic [9:0]  ySum;

`ifdef FB_WRITE_VBLANK_ONLY_EN
    assign permit = vblank;
`else
    logic unusedVblank;
    assign unusedVblank = vblank;
    assign permit       = 1'b1;
`endif

    assign accept  = bus.req_valid && bus.req_ready;
    // One extra bit on each sum so a large w/h can never wrap past the screen edge.
    assign xSum    = {1'b0, xQ} + {1'b0, wQ};
    assign ySum    = {1'b0, yQ} + {1'b0, hQ};
    assign empty   = (wQ == '0) || (hQ == '0) ||
                     ({1'b0, xQ} >= H_RES_L) || ({1'b0, yQ} >= V_RES_L);
    assign lastCol = (({1'b0, cx} + 11'd1) == xEnd);
    assign lastRow = (({1'b0, cy} + 10'd1) == yEnd);

    assign bus.req_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign state_dbg     = state;

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state <= IDLE;
        else         state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = CLIP;
            CLIP:    stateNext = empty ? DONE : WRITE;
            WRITE:   if (permit && lastCol && lastRow) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            xQ          <= '0;
            yQ          <= '0;
            wQ          <= '0;
            hQ          <= '0;
            colorQ      <= '0;
            cx          <= '0;
            cy          <= '0;
            xEnd        <= '0;
            yEnd        <= '0;
            rowBase     <= '0;
            clip_flag   <= 1'b0;
            done        <= 1'b0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
        end else begin
            done      <= (state == DONE);
            bus.wr_en <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    xQ        <= bus.req_x;
                    yQ        <= bus.req_y;
                    wQ        <= bus.req_w;
                    hQ        <= bus.req_h;
                    colorQ    <= bus.req_color;
                    clip_flag <= 1'b0;
                end
                CLIP: begin
                    xEnd      <= (xSum > H_RES_L) ? H_RES_L : xSum;
                    yEnd      <= (ySum > V_RES_L) ? V_RES_L : ySum;
                    clip_flag <= !empty && ((xSum > H_RES_L) || (ySum > V_RES_L));
                    // y*640 as shift-and-add: y*512 + y*128.
                    rowBase   <= ADDR_W'({yQ, 9'b0}) + ADDR_W'({yQ, 7'b0});
                    cx        <= xQ;
                    cy        <= yQ;
                end
                WRITE: if (permit) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= rowBase + ADDR_W'(cx);
                    bus.wr_data <= colorQ;
                    if (lastCol) begin
                        cx      <= xQ;
                        cy      <= cy + 9'd1;
                        rowBase <= rowBase + ADDR_W'(H_RES);
                    end else begin
                        cx      <= cx + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
